// File: rtl/can_pkg.sv
// Shared CAN receive-path types and constants.
package can_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2
    } can_state_t;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    localparam int unsigned STUFF_LIMIT_DEFAULT = 5;
    localparam int unsigned IDLE_BITS_DEFAULT   = 11;

    localparam int unsigned RUN_CNT_W = 3;
    localparam int unsigned REC_CNT_W = 4;

endpackage

// File: rtl/can_bit_destuff_if.sv
// Bit-stream bundle between the bus front end, the de-stuffer and the frame controller.
interface can_bit_destuff_if;

    logic can_rx;
    logic sample_point;
    logic stuff_en;
    logic frame_end;
    logic rx_sampled;
    logic bit_valid;
    logic bit_out;
    logic stuff_bit;
    logic stuff_err;
    logic sof;
    logic bus_idle;

    modport master (
        output can_rx,
        output sample_point,
        output stuff_en,
        output frame_end,
        input  rx_sampled,
        input  bit_valid,
        input  bit_out,
        input  stuff_bit,
        input  stuff_err,
        input  sof,
        input  bus_idle
    );

    modport slave (
        input  can_rx,
        input  sample_point,
        input  stuff_en,
        input  frame_end,
        output rx_sampled,
        output bit_valid,
        output bit_out,
        output stuff_bit,
        output stuff_err,
        output sof,
        output bus_idle
    );

endinterface

// File: rtl/can_rx_sync.sv
// Multi-flop synchroniser for the asynchronous CAN RX pin; resets to recessive.
module can_rx_sync
    import can_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_rx
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{CAN_RECESSIVE}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign o_rx = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/can_bit_destuff.sv
// CAN receive de-stuffer: samples the synchronised bus at each sample point,
// tracks bus integration / SOF, removes stuff bits and flags stuff errors.
module can_bit_destuff
    import can_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STUFF_LIMIT = STUFF_LIMIT_DEFAULT,
    parameter int unsigned IDLE_BITS   = IDLE_BITS_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    can_bit_destuff_if.slave bus
);

    localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(STUFF_LIMIT);
    localparam logic [REC_CNT_W-1:0] REC_LIMIT = REC_CNT_W'(IDLE_BITS);

    logic w_rx;

    can_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk  (clk),
        .rst  (rst),
        .i_rx (bus.can_rx),
        .o_rx (w_rx)
    );

    can_state_t           r_state;
    logic [REC_CNT_W-1:0] r_rec_cnt;
    logic [RUN_CNT_W-1:0] r_run_cnt;
    logic                 r_last;
    logic                 r_rx_sampled;
    logic                 r_bit_valid;
    logic                 r_bit_out;
    logic                 r_stuff_bit;
    logic                 r_stuff_err;
    logic                 r_sof;
    logic                 r_bus_idle;

    can_state_t           w_state_n;
    logic [REC_CNT_W-1:0] w_rec_cnt_n;
    logic [RUN_CNT_W-1:0] w_run_cnt_n;
    logic                 w_last_n;
    logic                 w_rx_sampled_n;
    logic                 w_bit_valid_n;
    logic                 w_bit_out_n;
    logic                 w_stuff_bit_n;
    logic                 w_stuff_err_n;
    logic                 w_sof_n;
    logic                 w_bus_idle_n;
    logic [REC_CNT_W-1:0] w_rec_inc;

    // Saturating recessive-count increment used during bus integration.
    assign w_rec_inc = (r_rec_cnt >= REC_LIMIT) ? REC_LIMIT
                                                : r_rec_cnt + REC_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            r_rec_cnt    <= '0;
            r_run_cnt    <= '0;
            r_last       <= CAN_RECESSIVE;
            r_rx_sampled <= CAN_RECESSIVE;
            r_bit_valid  <= 1'b0;
            r_bit_out    <= 1'b0;
            r_stuff_bit  <= 1'b0;
            r_stuff_err  <= 1'b0;
            r_sof        <= 1'b0;
            r_bus_idle   <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_rec_cnt    <= w_rec_cnt_n;
            r_run_cnt    <= w_run_cnt_n;
            r_last       <= w_last_n;
            r_rx_sampled <= w_rx_sampled_n;
            r_bit_valid  <= w_bit_valid_n;
            r_bit_out    <= w_bit_out_n;
            r_stuff_bit  <= w_stuff_bit_n;
            r_stuff_err  <= w_stuff_err_n;
            r_sof        <= w_sof_n;
            r_bus_idle   <= w_bus_idle_n;
        end
    end

    always_comb begin
        w_state_n      = r_state;
        w_rec_cnt_n    = r_rec_cnt;
        w_run_cnt_n    = r_run_cnt;
        w_last_n       = r_last;
        w_rx_sampled_n = r_rx_sampled;
        w_bit_valid_n  = 1'b0;
        w_bit_out_n    = 1'b0;
        w_stuff_bit_n  = 1'b0;
        w_stuff_err_n  = 1'b0;
        w_sof_n        = 1'b0;
        w_bus_idle_n   = r_bus_idle;

        if (bus.sample_point) begin
            w_rx_sampled_n = w_rx;
        end

        // frame_end overrides any sample taken in the same cycle.
        if (bus.frame_end) begin
            w_state_n    = HUNT;
            w_rec_cnt_n  = '0;
            w_bus_idle_n = 1'b0;
        end else if (bus.sample_point) begin
            case (r_state)
                HUNT: begin
                    if (w_rx == CAN_RECESSIVE) begin
                        w_rec_cnt_n = w_rec_inc;
                        if (w_rec_inc == REC_LIMIT) begin
                            w_state_n    = IDLE;
                            w_bus_idle_n = 1'b1;
                        end
                    end else begin
                        w_rec_cnt_n = '0;
                    end
                end

                IDLE: begin
                    if (w_rx == CAN_DOMINANT) begin
                        w_sof_n       = 1'b1;
                        w_bit_valid_n = 1'b1;
                        w_bit_out_n   = CAN_DOMINANT;
                        w_run_cnt_n   = RUN_CNT_W'(1);
                        w_last_n      = CAN_DOMINANT;
                        w_bus_idle_n  = 1'b0;
                        w_state_n     = FRAME;
                    end
                end

                FRAME: begin
                    if (!bus.stuff_en) begin
                        w_bit_valid_n = 1'b1;
                        w_bit_out_n   = w_rx;
                        w_run_cnt_n   = RUN_CNT_W'(1);
                        w_last_n      = w_rx;
                    end else if (r_run_cnt < RUN_LIMIT) begin
                        w_bit_valid_n = 1'b1;
                        w_bit_out_n   = w_rx;
                        if (w_rx == r_last) begin
                            w_run_cnt_n = r_run_cnt + RUN_CNT_W'(1);
                        end else begin
                            w_run_cnt_n = RUN_CNT_W'(1);
                            w_last_n    = w_rx;
                        end
                    end else if (w_rx != r_last) begin
                        w_stuff_bit_n = 1'b1;
                        w_run_cnt_n   = RUN_CNT_W'(1);
                        w_last_n      = w_rx;
                    end else begin
                        w_stuff_err_n = 1'b1;
                        w_state_n     = HUNT;
                        w_rec_cnt_n   = '0;
                    end
                end

                default: begin
                    w_state_n   = HUNT;
                    w_rec_cnt_n = '0;
                end
            endcase
        end
    end

    assign bus.rx_sampled = r_rx_sampled;
    assign bus.bit_valid  = r_bit_valid;
    assign bus.bit_out    = r_bit_out;
    assign bus.stuff_bit  = r_stuff_bit;
    assign bus.stuff_err  = r_stuff_err;
    assign bus.sof        = r_sof;
    assign bus.bus_idle   = r_bus_idle;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Directed bench for can_bit_destuff: bus integration, SOF, stuffing, frame_end and reset.
module tb_can_bit_destuff;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [5:0] obs;   // {bit_valid, bit_out, stuff_bit, stuff_err, sof, bus_idle}
    logic       rxs;

    can_bit_destuff_if bus_if ();

    can_bit_destuff #(
        .SYNC_STAGES (2),
        .STUFF_LIMIT (5),
        .IDLE_BITS   (11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [5:0] outs();
        return {bus_if.bit_valid, bus_if.bit_out, bus_if.stuff_bit,
                bus_if.stuff_err, bus_if.sof, bus_if.bus_idle};
    endfunction

    // Present a bus level, let it pass the synchroniser, pulse sample_point, capture outputs.
    task automatic sp(input logic b, input logic fe);
        bus_if.can_rx = b;
        repeat (3) @(negedge clk);
        bus_if.sample_point = 1'b1;
        bus_if.frame_end    = fe;
        @(negedge clk);
        bus_if.sample_point = 1'b0;
        bus_if.frame_end    = 1'b0;
        obs = outs();
        rxs = bus_if.rx_sampled;
    endtask

    task automatic do_reset();
        bus_if.can_rx       = 1'b1;
        bus_if.sample_point = 1'b0;
        bus_if.frame_end    = 1'b0;
        bus_if.stuff_en     = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 11; i++) sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL go_idle: got %b expected %b", obs, 6'b000001);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (outs() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b", outs(), 6'b000000);
        end
        checks++;
        if (bus_if.rx_sampled !== 1'b1) begin
            errors++;
            $display("FAIL reset_rx_sampled: got %b expected 1", bus_if.rx_sampled);
        end
    endtask

    task automatic test_bus_idle();
        for (int i = 1; i <= 10; i++) begin
            sp(1'b1, 1'b0);
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL idle_count_%0d: got %b expected %b", i, obs, 6'b000000);
            end
        end
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL idle_11th: got %b expected %b", obs, 6'b000001);
        end
        do_reset();
        for (int i = 0; i < 5; i++) sp(1'b1, 1'b0);
        sp(1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            sp(1'b1, 1'b0);
            checks++;
            if (obs[0] !== 1'b0) begin
                errors++;
                $display("FAIL idle_restart_%0d: got %b expected 0", i, obs[0]);
            end
        end
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL idle_restart_11th: got %b expected %b", obs, 6'b000001);
        end
    endtask

    task automatic test_sof();
        bus_if.stuff_en = 1'b1;
        sp(1'b0, 1'b0);
        checks++;
        if (obs !== 6'b100010) begin
            errors++;
            $display("FAIL sof: got %b expected %b", obs, 6'b100010);
        end
        checks++;
        if (rxs !== 1'b0) begin
            errors++;
            $display("FAIL sof_rx_sampled: got %b expected 0", rxs);
        end
        @(negedge clk);
        checks++;
        if (outs() !== 6'b000000) begin
            errors++;
            $display("FAIL sof_pulse_width: got %b expected %b", outs(), 6'b000000);
        end
    endtask

    task automatic test_stuff_bit();
        for (int i = 0; i < 4; i++) begin
            sp(1'b0, 1'b0);
            checks++;
            if (obs !== 6'b100000) begin
                errors++;
                $display("FAIL stuff_run_%0d: got %b expected %b", i, obs, 6'b100000);
            end
        end
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b001000) begin
            errors++;
            $display("FAIL stuff_bit: got %b expected %b", obs, 6'b001000);
        end
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b110000) begin
            errors++;
            $display("FAIL after_stuff: got %b expected %b", obs, 6'b110000);
        end
    endtask

    task automatic test_stuff_err();
        bus_if.frame_end = 1'b1;
        @(negedge clk);
        bus_if.frame_end = 1'b0;
        go_idle();
        sp(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sp(1'b1, 1'b0);
            checks++;
            if (obs !== 6'b110000) begin
                errors++;
                $display("FAIL err_run_%0d: got %b expected %b", i, obs, 6'b110000);
            end
        end
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b000100) begin
            errors++;
            $display("FAIL stuff_err: got %b expected %b", obs, 6'b000100);
        end
        for (int i = 1; i <= 10; i++) begin
            sp(1'b1, 1'b0);
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL err_reidle_%0d: got %b expected %b", i, obs, 6'b000000);
            end
        end
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b000001) begin
            errors++;
            $display("FAIL err_reidle_11th: got %b expected %b", obs, 6'b000001);
        end
    endtask

    task automatic test_no_stuff();
        sp(1'b0, 1'b0);
        bus_if.stuff_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sp(1'b0, 1'b0);
            checks++;
            if (obs !== 6'b100000) begin
                errors++;
                $display("FAIL nostuff_%0d: got %b expected %b", i, obs, 6'b100000);
            end
        end
        // The last unstuffed 0 opens the fresh run, so four more 0s complete it.
        bus_if.stuff_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sp(1'b0, 1'b0);
            checks++;
            if (obs !== 6'b100000) begin
                errors++;
                $display("FAIL reenable_%0d: got %b expected %b", i, obs, 6'b100000);
            end
        end
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b001000) begin
            errors++;
            $display("FAIL reenable_stuff: got %b expected %b", obs, 6'b001000);
        end
    endtask

    task automatic test_frame_end();
        sp(1'b1, 1'b1);
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL frame_end_pulses: got %b expected %b", obs, 6'b000000);
        end
        checks++;
        if (rxs !== 1'b1) begin
            errors++;
            $display("FAIL frame_end_rx_sampled: got %b expected 1", rxs);
        end
        sp(1'b0, 1'b0);
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL frame_end_hunt: got %b expected %b", obs, 6'b000000);
        end
    endtask

    task automatic test_reset_mid_frame();
        go_idle();
        sp(1'b0, 1'b0);
        sp(1'b1, 1'b0);
        checks++;
        if (obs !== 6'b110000) begin
            errors++;
            $display("FAIL mid_frame_bit: got %b expected %b", obs, 6'b110000);
        end
        bus_if.can_rx = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus_if.sample_point = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.sample_point = 1'b0;
        checks++;
        if (outs() !== 6'b000000) begin
            errors++;
            $display("FAIL rst_mid_outs: got %b expected %b", outs(), 6'b000000);
        end
        checks++;
        if (bus_if.rx_sampled !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_rx_sampled: got %b expected 1", bus_if.rx_sampled);
        end
        sp(1'b0, 1'b0);
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL rst_no_sof: got %b expected %b", obs, 6'b000000);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus_if.can_rx       = 1'b1;
        bus_if.sample_point = 1'b0;
        bus_if.frame_end    = 1'b0;
        bus_if.stuff_en     = 1'b1;
        test_reset();
        test_bus_idle();
        test_sof();
        test_stuff_bit();
        test_stuff_err();
        test_no_stuff();
        test_frame_end();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/can_bit_destuff.md
Name: can_bit_destuff

Overview:
Receive-side bit-stream stage directly downstream of the CAN time-quantum/bit-timing generator. It consumes that block's sample_point pulse and produces one de-stuffed data bit per nominal bit time for the frame controller.
- Synchronises raw CAN RX into clk.
- Samples the bus at each sample_point.
- Removes stuff bits and flags stuff errors.
- Tracks bus-idle (bus integration) and start-of-frame.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the RX synchroniser (min 2).
STUFF_LIMIT, 5, identical consecutive bits after which a complementary stuff bit is required.
IDLE_BITS, 11, consecutive recessive samples required to declare bus idle.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
can_rx  in  1  raw asynchronous CAN receive pin (1 = recessive)
sample_point  in  1  single-cycle pulse from the bit-timing generator; sample the bus this cycle
stuff_en  in  1  from frame controller; 1 = stuffing rules active (SOF through CRC sequence)
frame_end  in  1  single-cycle pulse from frame controller: frame finished or aborted, re-enter bus integration
rx_sampled  out  1  last sampled bus value, raw and not de-stuffed
bit_valid  out  1  single-cycle pulse: bit_out carries a de-stuffed data bit
bit_out  out  1  de-stuffed data bit, valid with bit_valid
stuff_bit  out  1  single-cycle pulse: a stuff bit was removed
stuff_err  out  1  single-cycle pulse: stuff rule violated
sof  out  1  single-cycle pulse: start-of-frame dominant bit detected
bus_idle  out  1  level: bus integration complete, no frame in progress

Behaviour:
- Synchroniser: all SYNC_STAGES flops reset to 1. The sampled value is the last synchroniser stage in the sample_point cycle.
- All outputs are registered. Pulses assert exactly one cycle after the sample_point cycle and last one cycle. Pulses are 0 on every cycle with no sample_point.
- Reset values:
  - rx_sampled=1.
  - bit_out, bit_valid, stuff_bit, stuff_err, sof = 0.
  - bus_idle=0.
  - state=HUNT, recessive count=0, run count=0, last value=1.
- State machine (can_pkg enum) on each sample_point:
  - HUNT:
    - Sample 1: recessive count +1, saturating at IDLE_BITS.
    - Sample 0: recessive count cleared.
    - When the count reaches IDLE_BITS, go to IDLE; bus_idle=1 from the following cycle.
  - IDLE:
    - Sample 1: stay in IDLE.
    - Sample 0: sof=1, bit_valid=1, bit_out=0, run count=1, last value=0, bus_idle=0, go to FRAME.
  - FRAME with stuff_en=1:
    - Run count < STUFF_LIMIT: emit bit_valid with bit_out=sample. If sample==last value, run count +1; else run count=1 and last value=sample.
    - Run count == STUFF_LIMIT, sample != last value: stuff_bit=1, no bit_valid, run count=1, last value=sample.
    - Run count == STUFF_LIMIT, sample == last value: stuff_err=1, no bit_valid, go to HUNT with recessive count=0.
  - FRAME with stuff_en=0: every sample emits bit_valid/bit_out. Run count forced to 1 and last value=sample, so re-enabling starts a fresh run.
- Run count is 3 bits and never exceeds STUFF_LIMIT. Recessive count is 4 bits.
- frame_end in any state: go to HUNT, recessive count=0, bus_idle=0.
  - Takes priority over a simultaneous sample_point; that sample is discarded with no pulses.
  - rx_sampled still updates.
- rst at any time, including mid-frame: all state returns to reset values in the same cycle. No pulse is generated for a sample_point coincident with rst.
- The tq_tick/segment signals of the timing generator are not used. Resynchronisation is out of scope.

Decomposition:
- Shared package can_pkg holds:
  - the state enum (HUNT, IDLE, FRAME);
  - CAN_DOMINANT=1'b0 and CAN_RECESSIVE=1'b1;
  - STUFF_LIMIT_DEFAULT=5 and IDLE_BITS_DEFAULT=11.
- One sub-module, can_rx_sync: parameterised SYNC_STAGES flop chain, reset to recessive.
- De-stuff FSM and counters live in can_bit_destuff.

Test Plan:
1. After reset, can_rx=1, 11 sample_points -> bus_idle=0 through the 10th and 1 the cycle after the 11th; a 0 at the 6th restarts the count (bus_idle needs 11 more).
2. Idle bus, can_rx=0 at a sample_point -> next cycle sof=1, bit_valid=1, bit_out=0, bus_idle=0.
3. stuff_en=1, samples SOF 0, 0,0,0,0, then 1, then 1 -> five bit_valid(0), then stuff_bit=1 with no bit_valid, then bit_valid(1).
4. stuff_en=1 in FRAME, six consecutive 1 samples -> five bit_valid(1), then stuff_err=1; bus_idle returns only after 11 further recessive samples.
5. stuff_en=0 in FRAME, eight consecutive 0 samples -> eight bit_valid(0), no stuff_bit/stuff_err; re-enable, five 0 then 1 -> stuff_bit on the sixth.
6. frame_end coincident with sample_point mid-frame -> no pulses, state HUNT. Separately, rst mid-frame -> all outputs at reset values, bus_idle=0, next dominant does not raise sof.
